reg_pop_sequencer: RTL and testbench

Read-side companion to the incrementing register: takes the register's current value as a memory address, performs a handshaked memory read, returns the word, then pulses the register's increment controls so the pointer advances. It sits between the instruction control path and the data memory port and implements stack pop, post-increment load and peek on any incrementing register.

---
 rtl/reg_pop_sequencer_pkg.sv | 19 +
 rtl/reg_pop_sequencer_dff.sv | 20 ++
 rtl/reg_pop_sequencer.sv | 104 ++++++++++
 tb/tb_reg_pop_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pop_sequencer_pkg.sv
// Shared state encoding and small helpers for the pop sequencer.
package reg_pop_sequencer_pkg;

    localparam logic [1:0] STATE_IDLE = 2'd0;
    localparam logic [1:0] STATE_READ = 2'd1;
    localparam logic [1:0] STATE_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = STATE_IDLE,
        ST_READ = STATE_READ,
        ST_DONE = STATE_DONE
    } pop_state_t;

    // Anything past IDLE counts as an operation in flight.
    function automatic logic state_is_busy(input pop_state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/reg_pop_sequencer_dff.sv
// Enabled D flip-flop with asynchronous active-high clear.
module reg_pop_sequencer_dff #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled; reset clears immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= '0;
        else if (enable)
            q <= d;
    end

endmodule

// File: rtl/reg_pop_sequencer.sv
// Reads memory at the incrementing register's value, returns the word and
// then pulses the register's increment (unless peeking).
module reg_pop_sequencer
    import reg_pop_sequencer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pop_request,
    input  logic             pop_peek,
    input  logic             abort,
    output logic             busy,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic [WIDTH-1:0] reg_value,
    output logic [WIDTH-1:0] reg_increment,
    output logic             reg_increment_enable,
    output logic [WIDTH-1:0] mem_address,
    output logic             mem_read,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_data
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    pop_state_t state_q;
    pop_state_t state_d;
    logic       peek_flag;
    logic       accept;
    logic       capture;

    // A pop is accepted only from IDLE; busy requests are simply dropped.
    assign accept  = (state_q == ST_IDLE) && pop_request;
    // abort outranks a same-cycle mem_ready, so the data is not captured.
    assign capture = (state_q == ST_READ) && !abort && mem_ready;

    // State register; async reset drops mem_read/busy at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Peek is remembered for the whole operation so DONE can gate the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            peek_flag <= 1'b0;
        else if (accept)
            peek_flag <= pop_peek;
    end

    // Next-state and decoded outputs.
    always_comb begin
        state_d              = state_q;
        mem_read             = 1'b0;
        pop_valid            = 1'b0;
        reg_increment_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_request)
                    state_d = ST_READ;
            end
            ST_READ: begin
                mem_read = 1'b1;
                if (abort)
                    state_d = ST_IDLE;
                else if (mem_ready)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                // abort is deliberately not looked at here: the read is done.
                pop_valid            = 1'b1;
                reg_increment_enable = ~peek_flag;
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy          = state_is_busy(state_q);
    assign reg_increment = STEP_W;

    // Pointer is frozen at accept so later register writes cannot move the read.
    reg_pop_sequencer_dff #(.WIDTH(WIDTH)) u_addr (
        .clock  (clock),
        .reset  (reset),
        .enable (accept),
        .d      (reg_value),
        .q      (mem_address)
    );

    // Returned word holds until the next completed pop.
    reg_pop_sequencer_dff #(.WIDTH(WIDTH)) u_data (
        .clock  (clock),
        .reset  (reset),
        .enable (capture),
        .d      (mem_data),
        .q      (pop_data)
    );

endmodule

// File: tb/tb_reg_pop_sequencer.sv
// Directed plus randomized bench for reg_pop_sequencer with a small
// incrementing-register model attached to the increment port.
module tb_reg_pop_sequencer;

    localparam int WIDTH = 16;
    localparam int STEP  = 1;
    localparam logic [15:0] STEP_W = 16'(STEP);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pop_request = 1'b0;
    logic        pop_peek = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic [15:0] reg_value;
    logic [15:0] reg_increment;
    logic        reg_increment_enable;
    logic [15:0] mem_address;
    logic        mem_read;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = 16'h0;

    // Register attached to the sequencer; a write beats the increment.
    logic [15:0] tb_reg = 16'h0;
    logic        reg_wr = 1'b0;
    logic [15:0] reg_wdata = 16'h0;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: where the pointer should be and the last returned word.
    logic [15:0] m_ptr  = 16'h0;
    logic [15:0] m_last = 16'h0;

    reg_pop_sequencer #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock                (clock),
        .reset                (reset),
        .pop_request          (pop_request),
        .pop_peek             (pop_peek),
        .abort                (abort),
        .busy                 (busy),
        .pop_valid            (pop_valid),
        .pop_data             (pop_data),
        .reg_value            (reg_value),
        .reg_increment        (reg_increment),
        .reg_increment_enable (reg_increment_enable),
        .mem_address          (mem_address),
        .mem_read             (mem_read),
        .mem_ready            (mem_ready),
        .mem_data             (mem_data)
    );

    always #5 clock = ~clock;

    assign reg_value = tb_reg;

    always @(posedge clock) begin
        if (reg_wr)
            tb_reg <= reg_wdata;
        else if (reg_increment_enable)
            tb_reg <= tb_reg + reg_increment;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_reg(input logic [15:0] v);
        reg_wr    = 1'b1;
        reg_wdata = v;
        step();
        reg_wr = 1'b0;
        m_ptr  = v;
    endtask

    // One pop: accept, wait_n cycles without mem_ready, then the ready cycle.
    task automatic do_pop(input logic pk, input int wait_n, input logic [15:0] d,
                          input logic ab, input logic perturb);
        logic [15:0] addr;
        int rd_cycles;
        rd_cycles = 0;
        addr = m_ptr;
        pop_request = 1'b1;
        pop_peek    = pk;
        step();
        pop_request = 1'b0;
        pop_peek    = 1'($urandom);
        chk("busy_in_read", busy, 1);
        chk("addr_latched", mem_address, addr);
        if (mem_read) rd_cycles++;
        for (int i = 0; i < wait_n; i++) begin
            mem_data    = 16'($urandom);
            mem_ready   = 1'b0;
            pop_request = 1'($urandom);
            if (perturb && i == 0) begin
                reg_wr    = 1'b1;
                reg_wdata = 16'($urandom);
                m_ptr     = reg_wdata;
            end
            step();
            reg_wr      = 1'b0;
            pop_request = 1'b0;
            chk("no_valid_while_wait", pop_valid, 0);
            chk("addr_stable", mem_address, addr);
            if (mem_read) rd_cycles++;
        end
        mem_ready = 1'b1;
        mem_data  = d;
        abort     = ab;
        step();
        mem_ready = 1'b0;
        abort     = 1'b0;
        chk("mem_read_cycles", rd_cycles, wait_n + 1);
        if (ab) begin
            chk("abort_no_valid", pop_valid, 0);
            chk("abort_no_inc", reg_increment_enable, 0);
            chk("abort_idle", busy, 0);
            chk("abort_data_kept", pop_data, m_last);
            step();
            chk("abort_reg_unchanged", reg_value, m_ptr);
        end else begin
            chk("pop_valid", pop_valid, 1);
            chk("pop_data", pop_data, d);
            chk("inc_enable", reg_increment_enable, {31'b0, ~pk});
            chk("inc_value", reg_increment, STEP_W);
            chk("busy_in_done", busy, 1);
            m_last = d;
            abort  = 1'($urandom);
            step();
            abort = 1'b0;
            if (!pk) m_ptr = m_ptr + STEP_W;
            chk("idle_after_done", busy, 0);
            chk("valid_one_cycle", pop_valid, 0);
            chk("reg_after_pop", reg_value, m_ptr);
        end
    endtask

    initial begin
        logic [15:0] cur;
        logic [15:0] prev;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_valid", pop_valid, 0);
        chk("rst_inc_en", reg_increment_enable, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_inc_value", reg_increment, STEP_W);
        reset = 1'b0;
        step();

        // Basic pop with zero wait.
        set_reg(16'h0100);
        do_pop(1'b0, 0, 16'hBEEF, 1'b0, 1'b0);

        // Peek with three wait cycles: no increment.
        do_pop(1'b1, 3, 16'h1234, 1'b0, 1'b0);

        // Pointer wrap handled by the register.
        set_reg(16'hFFFF);
        do_pop(1'b0, 1, 16'hA5A5, 1'b0, 1'b0);
        chk("wrap_zero", reg_value, 16'h0000);

        // abort together with mem_ready.
        do_pop(1'b0, 2, 16'h5555, 1'b1, 1'b0);

        // mem_ready while idle is ignored.
        mem_ready = 1'b1;
        mem_data  = 16'hDEAD;
        step();
        mem_ready = 1'b0;
        chk("idle_ready_busy", busy, 0);
        chk("idle_ready_data", pop_data, m_last);

        // Back-to-back pops with request held and memory always ready.
        set_reg(16'h0200);
        pop_request = 1'b1;
        pop_peek    = 1'b0;
        mem_ready   = 1'b1;
        cur         = 16'($urandom);
        mem_data    = cur;
        step();
        for (int c = 1; c <= 11; c++) begin
            prev     = cur;
            cur      = 16'($urandom);
            mem_data = cur;
            chk("b2b_valid", pop_valid, {31'b0, (c % 3) == 2});
            chk("b2b_read", mem_read, {31'b0, (c % 3) == 1});
            if ((c % 3) == 1) chk("b2b_addr", mem_address, m_ptr);
            if ((c % 3) == 2) begin
                chk("b2b_data", pop_data, prev);
                m_last = prev;
                m_ptr  = m_ptr + STEP_W;
            end
            if (c == 11) begin
                pop_request = 1'b0;
                mem_ready   = 1'b0;
            end
            step();
        end
        chk("b2b_end_idle", busy, 0);
        chk("b2b_end_reg", reg_value, m_ptr);

        // Reset in the middle of a read.
        pop_request = 1'b1;
        step();
        pop_request = 1'b0;
        chk("pre_rst_read", mem_read, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_read", mem_read, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_data", pop_data, 0);
        m_last = 16'h0;
        #2 reset = 1'b0;
        step();
        chk("post_rst_idle", busy, 0);
        chk("post_rst_no_inc", reg_value, m_ptr);
        do_pop(1'b0, 0, 16'h7777, 1'b0, 1'b0);

        // Randomized pops against the model.
        for (int n = 0; n < 25; n++) begin
            do_pop(1'($urandom), int'($urandom_range(0, 4)), 16'($urandom),
                   ($urandom_range(0, 5) == 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
